// File: rtl/key_pkg.sv
// Shared definitions for the key-driven parameter editor: key indices, FSM encoding and
// the millisecond-to-cycle conversion used for hold/repeat timing.
package key_pkg;

  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_NEXT  = 2;
  localparam int unsigned KEY_ENTER = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StHold   = 2'd1,
    StRepeat = 2'd2,
    StCommit = 2'd3
  } state_e;

  function automatic logic [31:0] ms_to_cyc(input int unsigned clk_freq, input int unsigned ms);
    return clk_freq / 1000 * ms;
  endfunction

endpackage

// File: rtl/key_repeat_timer.sv
// Free-running hold timer with synchronous clear/enable; flags the long-press and
// auto-repeat terminal counts.
module key_repeat_timer #(
  parameter logic [31:0] LONG_CYC = 32'd25_000_000,
  parameter logic [31:0] REP_CYC  = 32'd5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic long_done,
  output logic rep_done
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign long_done = (cnt_q == LONG_CYC - 32'd1);
  assign rep_done  = (cnt_q == REP_CYC - 32'd1);

endmodule

// File: rtl/key_param_ctrl.sv
// Turns debounced active-low keys into saturating edits of PARAM_CNT working parameters,
// with long-press auto-repeat and a valid/ready commit of a parameter snapshot.
module key_param_ctrl
  import key_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned PARAM_CNT = 4,
  parameter int unsigned PARAM_W   = 16,
  parameter int unsigned PARAM_MAX = 1000,
  parameter int unsigned PARAM_DEF = 100,
  parameter int unsigned LONG_MS   = 500,
  parameter int unsigned REPEAT_MS = 100,
  localparam int unsigned SEL_W    = $clog2(PARAM_CNT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   keys_stable,
  output logic [SEL_W-1:0]             param_sel,
  output logic [PARAM_CNT*PARAM_W-1:0] param_val,
  output logic [PARAM_CNT*PARAM_W-1:0] cfg_data,
  output logic                         cfg_valid,
  input  logic                         cfg_ready,
  output logic                         busy
);

  localparam logic [31:0]        LONG_CYC = ms_to_cyc(CLK_FREQ, LONG_MS);
  localparam logic [31:0]        REP_CYC  = ms_to_cyc(CLK_FREQ, REPEAT_MS);
  localparam logic [PARAM_W-1:0] MAX_V    = PARAM_W'(PARAM_MAX);
  localparam logic [PARAM_W-1:0] DEF_V    = PARAM_W'(PARAM_DEF);
  localparam logic [SEL_W-1:0]   LAST_SEL = SEL_W'(PARAM_CNT - 1);

  state_e                         state_q, state_d;
  logic [3:0]                     hist_q;
  logic [3:0]                     held_q, held_d;
  logic [SEL_W-1:0]               sel_q, sel_d;
  logic [PARAM_W-1:0]             param_q [PARAM_CNT];
  logic [PARAM_W-1:0]             param_d [PARAM_CNT];
  logic [PARAM_CNT*PARAM_W-1:0]   cfg_q, cfg_d;
  logic                           valid_q, valid_d;

  logic one_low, pressed, step_req, step_up, tmr_clr, tmr_en, long_done, rep_done;
  logic [PARAM_W-1:0] cur_val, nxt_val;

  // A press needs exactly one key low, and that key must have been high last cycle.
  assign one_low = (keys_stable inside {4'b1110, 4'b1101, 4'b1011, 4'b0111});
  assign pressed = one_low && ((hist_q & ~keys_stable) != 4'b0000);

  key_repeat_timer #(
    .LONG_CYC (LONG_CYC),
    .REP_CYC  (REP_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .long_done (long_done),
    .rep_done  (rep_done)
  );

  always_comb begin
    state_d  = state_q;
    held_d   = held_q;
    sel_d    = sel_q;
    cfg_d    = cfg_q;
    valid_d  = valid_q;
    step_req = 1'b0;
    step_up  = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pressed) begin
          if (!keys_stable[KEY_UP] || !keys_stable[KEY_DOWN]) begin
            step_req = 1'b1;
            step_up  = !keys_stable[KEY_UP];
            held_d   = keys_stable;
            tmr_clr  = 1'b1;
            state_d  = StHold;
          end else if (!keys_stable[KEY_NEXT]) begin
            sel_d = (sel_q == LAST_SEL) ? '0 : sel_q + SEL_W'(1);
          end else begin
            cfg_d   = param_val;
            valid_d = 1'b1;
            state_d = StCommit;
          end
        end
      end
      StHold, StRepeat: begin
        if (keys_stable != held_q) begin
          state_d = StIdle;
        end else if ((state_q == StHold) ? long_done : rep_done) begin
          step_req = 1'b1;
          step_up  = !held_q[KEY_UP];
          tmr_clr  = 1'b1;
          state_d  = StRepeat;
        end else begin
          tmr_en = 1'b1;
        end
      end
      StCommit: begin
        if (cfg_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Saturating step applied to the selected parameter only.
  always_comb begin
    cur_val = param_q[sel_q];
    nxt_val = cur_val;
    if (step_up) begin
      if (cur_val < MAX_V) nxt_val = cur_val + PARAM_W'(1);
    end else if (cur_val != '0) begin
      nxt_val = cur_val - PARAM_W'(1);
    end
    for (int i = 0; i < PARAM_CNT; i++) begin
      param_d[i] = param_q[i];
    end
    if (step_req) param_d[sel_q] = nxt_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hist_q  <= 4'b1111;
      held_q  <= 4'b1111;
      sel_q   <= '0;
      cfg_q   <= {PARAM_CNT{DEF_V}};
      valid_q <= 1'b0;
      for (int i = 0; i < PARAM_CNT; i++) param_q[i] <= DEF_V;
    end else begin
      state_q <= state_d;
      hist_q  <= keys_stable;
      held_q  <= held_d;
      sel_q   <= sel_d;
      cfg_q   <= cfg_d;
      valid_q <= valid_d;
      for (int i = 0; i < PARAM_CNT; i++) param_q[i] <= param_d[i];
    end
  end

  always_comb begin
    param_val = '0;
    for (int i = 0; i < PARAM_CNT; i++) param_val[i*PARAM_W +: PARAM_W] = param_q[i];
  end

  assign param_sel = sel_q;
  assign cfg_data  = cfg_q;
  assign cfg_valid = valid_q;
  assign busy      = (state_q == StCommit);

endmodule

// File: tb/tb_key_param_ctrl.sv
// Bench for key_param_ctrl: constant-expectation tables and sequences, then random key
// traffic compared against an event-level reference model.
module tb_key_param_ctrl;

  localparam int LONG = 5;
  localparam int REP  = 2;
  localparam int MAXP = 10;
  localparam int DEFP = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  keys;
  logic        cfg_ready;
  logic [1:0]  param_sel;
  logic [63:0] param_val;
  logic [63:0] cfg_data;
  logic        cfg_valid;
  logic        busy;

  always #5 clk = ~clk;

  key_param_ctrl #(
    .CLK_FREQ  (1000),
    .PARAM_CNT (4),
    .PARAM_W   (16),
    .PARAM_MAX (MAXP),
    .PARAM_DEF (DEFP),
    .LONG_MS   (LONG),
    .REPEAT_MS (REP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .keys_stable (keys),
    .param_sel   (param_sel),
    .param_val   (param_val),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 idle, 1 key held (age = cycles since press), 2 committing.
  int         m_p [4];
  int         m_cfg [4];
  int         m_sel;
  int         m_mode;
  int         m_age;
  logic       m_valid;
  logic [3:0] m_hist;
  logic [3:0] m_held;

  function automatic int pv(input int i);
    return int'(param_val[i*16 +: 16]);
  endfunction

  function automatic int cv(input int i);
    return int'(cfg_data[i*16 +: 16]);
  endfunction

  function automatic int sat(input int v, input bit up);
    if (up) return (v < MAXP) ? v + 1 : v;
    return (v > 0) ? v - 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic [3:0] k, input logic r, input logic rs);
    int  zeros;
    int  kidx;
    bit  press;
    if (rs) begin
      for (int i = 0; i < 4; i++) begin
        m_p[i]   = DEFP;
        m_cfg[i] = DEFP;
      end
      m_sel = 0; m_mode = 0; m_age = 0; m_valid = 1'b0;
      m_hist = 4'b1111; m_held = 4'b1111;
    end else begin
      zeros = 0;
      kidx  = 0;
      for (int i = 0; i < 4; i++) if (!k[i]) begin zeros++; kidx = i; end
      press = (zeros == 1) && m_hist[kidx];
      case (m_mode)
        0: if (press) begin
          if (kidx <= 1) begin
            m_p[m_sel] = sat(m_p[m_sel], kidx == 0);
            m_held = k; m_age = 0; m_mode = 1;
          end else if (kidx == 2) begin
            m_sel = (m_sel + 1) % 4;
          end else begin
            for (int i = 0; i < 4; i++) m_cfg[i] = m_p[i];
            m_valid = 1'b1; m_mode = 2;
          end
        end
        1: if (k != m_held) begin
          m_mode = 0;
        end else begin
          m_age++;
          if (m_age == LONG || (m_age > LONG && (m_age - LONG) % REP == 0))
            m_p[m_sel] = sat(m_p[m_sel], m_held[0] == 1'b0);
        end
        default: if (r) begin
          m_valid = 1'b0; m_mode = 0;
        end
      endcase
      m_hist = k;
    end
  endtask

  task automatic compare_model();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("model param%0d", i), pv(i), m_p[i]);
      check($sformatf("model cfg%0d", i), cv(i), m_cfg[i]);
    end
    check("model sel", int'(param_sel), m_sel);
    check("model cfg_valid", int'(cfg_valid), int'(m_valid));
    check("model busy", int'(busy), (m_mode == 2) ? 1 : 0);
  endtask

  task automatic cyc(input logic [3:0] k, input logic r, input logic rs);
    keys = k; cfg_ready = r; rst = rs;
    @(posedge clk);
    model_edge(k, r, rs);
    #1;
    compare_model();
  endtask

  typedef struct {
    logic [3:0] keys;
    int         e_sel;
    int         e_p0;
    int         e_p2;
  } vec_t;

  vec_t       tbl [18];
  int         exp3 [12];
  logic [3:0] pats [7];
  logic [3:0] k;

  initial begin
    tbl[0]  = '{4'b1110, 0, 9, 8};
    tbl[1]  = '{4'b1111, 0, 9, 8};
    tbl[2]  = '{4'b1110, 0, 10, 8};
    tbl[3]  = '{4'b1111, 0, 10, 8};
    tbl[4]  = '{4'b1110, 0, 10, 8};
    tbl[5]  = '{4'b1111, 0, 10, 8};
    tbl[6]  = '{4'b1100, 0, 10, 8};
    tbl[7]  = '{4'b1111, 0, 10, 8};
    tbl[8]  = '{4'b1011, 1, 10, 8};
    tbl[9]  = '{4'b1111, 1, 10, 8};
    tbl[10] = '{4'b1011, 2, 10, 8};
    tbl[11] = '{4'b1111, 2, 10, 8};
    tbl[12] = '{4'b1110, 2, 10, 9};
    tbl[13] = '{4'b1111, 2, 10, 9};
    tbl[14] = '{4'b1011, 3, 10, 9};
    tbl[15] = '{4'b1111, 3, 10, 9};
    tbl[16] = '{4'b1011, 0, 10, 9};
    tbl[17] = '{4'b1111, 0, 10, 9};
    exp3 = '{3, 3, 3, 3, 3, 4, 4, 5, 5, 6, 6, 7};
    pats = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1100, 4'b0000};

    // Reset state
    cyc(4'b1111, 1'b0, 1'b1);
    cyc(4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) check($sformatf("reset param%0d", i), pv(i), DEFP);
    check("reset sel", int'(param_sel), 0);
    check("reset cfg_valid", int'(cfg_valid), 0);
    check("reset busy", int'(busy), 0);

    // Single steps, saturation at the top, invalid two-key pattern, selection wrap
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].keys, 1'b0, 1'b0);
      check($sformatf("tbl%0d sel", i), int'(param_sel), tbl[i].e_sel);
      check($sformatf("tbl%0d param0", i), pv(0), tbl[i].e_p0);
      check($sformatf("tbl%0d param2", i), pv(2), tbl[i].e_p2);
      check($sformatf("tbl%0d param1", i), pv(1), DEFP);
    end

    // Walk down to the floor, then a DOWN press at 0 must stay at 0
    for (int i = 0; i < 12; i++) begin
      cyc(4'b1101, 1'b0, 1'b0);
      cyc(4'b1111, 1'b0, 1'b0);
    end
    check("down floor", pv(0), 0);
    cyc(4'b1101, 1'b0, 1'b0);
    check("down at zero", pv(0), 0);
    cyc(4'b1111, 1'b0, 1'b0);

    // Long press from 2: steps at press, +5, +7, +9, +11
    for (int i = 0; i < 2; i++) begin
      cyc(4'b1110, 1'b0, 1'b0);
      cyc(4'b1111, 1'b0, 1'b0);
    end
    check("pre-hold param0", pv(0), 2);
    for (int i = 0; i < 12; i++) begin
      cyc(4'b1110, 1'b0, 1'b0);
      check($sformatf("hold cycle%0d param0", i), pv(0), exp3[i]);
    end
    cyc(4'b1111, 1'b0, 1'b0);
    check("after release param0", pv(0), 7);
    cyc(4'b1111, 1'b0, 1'b0);
    check("idle no step param0", pv(0), 7);

    // Commit with back-pressure; keys ignored while waiting
    cyc(4'b0111, 1'b0, 1'b0);
    check("commit cfg_valid", int'(cfg_valid), 1);
    check("commit busy", int'(busy), 1);
    check("commit cfg0", cv(0), 7);
    check("commit cfg2", cv(2), 9);
    for (int i = 0; i < 4; i++) begin
      cyc((i % 2 == 1) ? 4'b1110 : 4'b1111, 1'b0, 1'b0);
      check($sformatf("wait%0d cfg_valid", i), int'(cfg_valid), 1);
      check($sformatf("wait%0d param0", i), pv(0), 7);
      check($sformatf("wait%0d cfg0", i), cv(0), 7);
    end
    cyc(4'b1111, 1'b1, 1'b0);
    check("accept cfg_valid", int'(cfg_valid), 0);
    check("accept busy", int'(busy), 0);
    cyc(4'b1110, 1'b0, 1'b0);
    check("post-commit up param0", pv(0), 8);
    cyc(4'b1111, 1'b0, 1'b0);

    // Two keys together, then reset in the middle of a commit
    cyc(4'b1100, 1'b0, 1'b0);
    check("up+down param0", pv(0), 8);
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b1101, 1'b0, 1'b0);
    cyc(4'b1111, 1'b0, 1'b0);
    cyc(4'b0111, 1'b0, 1'b0);
    check("pre-rst cfg_valid", int'(cfg_valid), 1);
    check("pre-rst cfg0", cv(0), 7);
    cyc(4'b1111, 1'b0, 1'b1);
    check("rst commit cfg_valid", int'(cfg_valid), 0);
    check("rst commit busy", int'(busy), 0);
    check("rst commit param0", pv(0), DEFP);
    check("rst commit cfg0", cv(0), DEFP);

    // Random traffic against the model
    k = 4'b1111;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 99) >= 85) begin
        k = pats[$urandom_range(0, 6)];
        if ($urandom_range(0, 9) == 0) k = 4'($urandom);
      end
      cyc(k, ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
